// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction queue: DEPTH-entry FIFO of (PC, INST) pairs with
// valid/ready handshakes and a synchronous flush for redirects.
module if_id_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              FLUSH,
    input  logic              IF_VALID,
    input  logic [ADDR_W-1:0] IF_PC,
    input  logic [DATA_W-1:0] IF_INST,
    output logic              IF_READY,
    input  logic              ID_STALL,
    output logic              ID_VALID,
    output logic [ADDR_W-1:0] ID_PC,
    output logic [DATA_W-1:0] ID_INST,
    output logic [CNT_W-1:0]  COUNT
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              push;
    logic              pop;

    // Handshake flags come from registered occupancy only, so there is no
    // combinational path from the fetch inputs to decode or from stall to ready.
    assign IF_READY = (count_q != FULL_CNT);
    assign ID_VALID = (count_q != '0);
    assign COUNT    = count_q;

    assign push = IF_VALID & IF_READY & ~FLUSH;
    assign pop  = ID_VALID & ~ID_STALL & ~FLUSH;

    // An empty queue presents a bubble of all zeros, which decode treats as a NOP.
    assign ID_PC   = ID_VALID ? pc_mem[rd_ptr]   : '0;
    assign ID_INST = ID_VALID ? inst_mem[rd_ptr] : '0;

    always_ff @(posedge CLK) begin
        if (push) begin
            pc_mem[wr_ptr]   <= IF_PC;
            inst_mem[wr_ptr] <= IF_INST;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else if (FLUSH) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, pass-through, backpressure, wrap-around,
// simultaneous push/pop, flush and asynchronous reset mid-operation.
module tb_if_id_queue;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);

    logic              CLK;
    logic              RST;
    logic              FLUSH;
    logic              IF_VALID;
    logic [ADDR_W-1:0] IF_PC;
    logic [DATA_W-1:0] IF_INST;
    logic              IF_READY;
    logic              ID_STALL;
    logic              ID_VALID;
    logic [ADDR_W-1:0] ID_PC;
    logic [DATA_W-1:0] ID_INST;
    logic [CNT_W-1:0]  COUNT;

    int tests_run = 0;
    int tests_failed = 0;

    if_id_queue #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RST(RST), .FLUSH(FLUSH),
        .IF_VALID(IF_VALID), .IF_PC(IF_PC), .IF_INST(IF_INST), .IF_READY(IF_READY),
        .ID_STALL(ID_STALL), .ID_VALID(ID_VALID), .ID_PC(ID_PC), .ID_INST(ID_INST),
        .COUNT(COUNT)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic logic [31:0] mk_inst(input logic [31:0] pc);
        return pc ^ 32'hDEAD_0000;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst);
        IF_VALID = v;
        IF_PC    = pc;
        IF_INST  = inst;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input int cnt);
        check({tag, "_valid"}, 32'(ID_VALID), 32'(cnt != 0));
        check({tag, "_pc"}, ID_PC, (cnt != 0) ? pc : 32'h0);
        check({tag, "_inst"}, ID_INST, (cnt != 0) ? mk_inst(pc) : 32'h0);
        check({tag, "_count"}, 32'(COUNT), 32'(cnt));
    endtask

    initial begin
        int pushed;
        int popped;
        int mcount;
        logic m_push;
        logic m_pop;

        RST = 1'b0; FLUSH = 1'b0; ID_STALL = 1'b0;
        drive(1'b0, 32'h0, 32'h0);

        // Asynchronous reset mid-cycle, checked before any clock edge
        #2 RST = 1'b1;
        #1;
        check("rst_valid", 32'(ID_VALID), 32'h0);
        check("rst_pc", ID_PC, 32'h0);
        check("rst_inst", ID_INST, 32'h0);
        check("rst_count", 32'(COUNT), 32'h0);
        check("rst_ready", 32'(IF_READY), 32'h1);
        tick();
        tick();
        RST = 1'b0;

        // Pass-through with decode never stalling
        IF_VALID = 1'b1; IF_PC = 32'h1000; IF_INST = 32'h2402_0001;
        tick();
        check("pt0_valid", 32'(ID_VALID), 32'h1);
        check("pt0_pc", ID_PC, 32'h1000);
        check("pt0_inst", ID_INST, 32'h2402_0001);
        check("pt0_count", 32'(COUNT), 32'h1);
        IF_PC = 32'h1004; IF_INST = 32'h2403_0002;
        tick();
        check("pt1_pc", ID_PC, 32'h1004);
        check("pt1_inst", ID_INST, 32'h2403_0002);
        check("pt1_count", 32'(COUNT), 32'h1);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check("pt2_valid", 32'(ID_VALID), 32'h0);
        check("pt2_pc", ID_PC, 32'h0);
        check("pt2_count", 32'(COUNT), 32'h0);

        // Fill with decode stalled, then backpressure
        ID_STALL = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h2000 + 32'(4 * i), mk_inst(32'h2000 + 32'(4 * i)));
            tick();
            check("fill_count", 32'(COUNT), 32'(i + 1));
        end
        check("full_ready", 32'(IF_READY), 32'h0);
        check_head("full_head", 32'h2000, 4);
        drive(1'b1, 32'h2010, mk_inst(32'h2010));
        tick();
        check_head("held", 32'h2000, 4);
        check("held_ready", 32'(IF_READY), 32'h0);
        ID_STALL = 1'b0;
        tick();
        check_head("drain0", 32'h2004, 3);
        check("drain0_ready", 32'(IF_READY), 32'h1);
        tick();
        check_head("drain1", 32'h2008, 3);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_head("drain2", 32'h200C, 2);
        tick();
        check_head("drain3", 32'h2010, 1);
        tick();
        check_head("drain4", 32'h0, 0);

        // Wrap-around stream with stall toggling; compared against a small occupancy model
        pushed = 0; popped = 0; mcount = 0;
        for (int cyc = 0; cyc < 60 && popped < 10; cyc++) begin
            ID_STALL = cyc[0];
            drive(pushed < 10, 32'h3000 + 32'(4 * pushed), mk_inst(32'h3000 + 32'(4 * pushed)));
            m_push = (pushed < 10) && (mcount != DEPTH);
            m_pop  = (mcount != 0) && !ID_STALL;
            check("wrap_ready", 32'(IF_READY), 32'(mcount != DEPTH));
            tick();
            if (m_push) pushed++;
            if (m_pop) popped++;
            mcount = mcount + int'(m_push) - int'(m_pop);
            check("wrap_count", 32'(COUNT), 32'(mcount));
            if (mcount != 0) check("wrap_pc", ID_PC, 32'h3000 + 32'(4 * popped));
        end
        check("wrap_all_popped", 32'(popped), 32'd10);
        drive(1'b0, 32'h0, 32'h0);
        ID_STALL = 1'b0;
        tick();
        check_head("wrap_end", 32'h0, 0);

        // Simultaneous push and pop at COUNT=2
        ID_STALL = 1'b1;
        drive(1'b1, 32'h4000, mk_inst(32'h4000));
        tick();
        drive(1'b1, 32'h4004, mk_inst(32'h4004));
        tick();
        check_head("pp_pre", 32'h4000, 2);
        ID_STALL = 1'b0;
        drive(1'b1, 32'h4008, mk_inst(32'h4008));
        tick();
        check_head("pp_both", 32'h4004, 2);
        drive(1'b0, 32'h0, 32'h0);
        tick();
        check_head("pp_tail", 32'h4008, 1);
        tick();
        check_head("pp_empty", 32'h0, 0);

        // Flush with push and pop pending
        ID_STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5000 + 32'(4 * i), mk_inst(32'h5000 + 32'(4 * i)));
            tick();
        end
        check_head("fl_pre", 32'h5000, 3);
        drive(1'b1, 32'h500C, mk_inst(32'h500C));
        ID_STALL = 1'b0;
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        check_head("fl_post", 32'h0, 0);
        check("fl_ready", 32'(IF_READY), 32'h1);
        drive(1'b1, 32'h6000, mk_inst(32'h6000));
        tick();
        check_head("fl_next", 32'h6000, 1);
        drive(1'b0, 32'h0, 32'h0);
        ID_STALL = 1'b1;
        tick();
        check_head("fl_hold", 32'h6000, 1);

        // Asynchronous reset with an entry queued
        #3 RST = 1'b1;
        #1;
        check_head("arst", 32'h0, 0);
        check("arst_ready", 32'(IF_READY), 32'h1);
        tick();
        RST = 1'b0;
        tick();
        check_head("arst_after", 32'h0, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
